// File: rtl/alu_ctrl_pkg.sv
// Shared types, constants and opcode helpers for the ALU issue controller.
package alu_ctrl_pkg;

    localparam int unsigned DIV_ITERS_DEFAULT = 64;
    localparam logic [63:0] INT64_MIN         = 64'h8000_0000_0000_0000;

    // Opcode and instruction-type encodings; these must track the alu definitions.
    localparam logic [10:0] OP_NOTHING = 11'd0;
    localparam logic [10:0] OP_ADD     = 11'd1;
    localparam logic [10:0] OP_SUB     = 11'd2;
    localparam logic [10:0] OP_XOR     = 11'd3;
    localparam logic [10:0] OP_SLL     = 11'd4;
    localparam logic [10:0] OP_DIV     = 11'd5;
    localparam logic [10:0] OP_DIVU    = 11'd6;
    localparam logic [10:0] OP_REM     = 11'd7;
    localparam logic [10:0] OP_REMU    = 11'd8;

    localparam logic [3:0] RTYPE = 4'd0;
    localparam logic [3:0] ITYPE = 4'd1;

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDivFix
    } issue_state_e;

    function automatic logic is_div_class(input logic [10:0] opcode);
        return (opcode == OP_DIV) || (opcode == OP_DIVU) ||
               (opcode == OP_REM) || (opcode == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [10:0] opcode);
        return (opcode == OP_DIV) || (opcode == OP_REM);
    endfunction

    function automatic logic is_rem(input logic [10:0] opcode);
        return (opcode == OP_REM) || (opcode == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring 64-bit divider: one quotient bit per cycle, sign handling on both ends.
// The last of the DIV_ITERS steps is folded combinationally into the result path, so
// the counter leaves DIV_RUN one cycle early and the fix-up cycle completes the step.
module div_iter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    input  logic        signed_i,
    input  logic        rem_sel_i,
    input  logic        stall_i,
    output logic        skip_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    localparam int unsigned     CntW     = $clog2(DIV_ITERS) + 1;
    localparam logic [CntW-1:0] CntStart = CntW'(DIV_ITERS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     rem_q, rem_d;
    logic [63:0]     quot_q, quot_d;
    logic [63:0]     dsor_q, dsor_d;
    logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic            rem_sel_q, rem_sel_d, skip_q, skip_d;

    logic        sign1, sign2, div_zero, div_ovf;
    logic [63:0] abs1, abs2;
    logic [64:0] rem_sh, diff;
    logic [63:0] st_rem, st_quot, fin_rem, fin_quot, q_fix, r_fix;

    // Operand magnitudes and the two cases that bypass iteration.
    always_comb begin
        sign1    = signed_i & dividend_i[63];
        sign2    = signed_i & divisor_i[63];
        abs1     = sign1 ? -dividend_i : dividend_i;
        abs2     = sign2 ? -divisor_i : divisor_i;
        div_zero = (divisor_i == '0);
        div_ovf  = signed_i && (dividend_i == INT64_MIN) && (divisor_i == '1);
        skip_o   = div_zero || div_ovf;
    end

    // One restoring step on the held state, plus sign fix-up of the final answer.
    always_comb begin
        rem_sh = {rem_q, quot_q[63]};
        diff   = rem_sh - {1'b0, dsor_q};
        if (!diff[64]) begin
            st_rem  = diff[63:0];
            st_quot = {quot_q[62:0], 1'b1};
        end else begin
            st_rem  = rem_sh[63:0];
            st_quot = {quot_q[62:0], 1'b0};
        end
        fin_quot = skip_q ? quot_q : st_quot;
        fin_rem  = skip_q ? rem_q : st_rem;
        q_fix    = neg_q_q ? -fin_quot : fin_quot;
        r_fix    = neg_r_q ? -fin_rem : fin_rem;
        result_o = rem_sel_q ? r_fix : q_fix;
        done_o   = (cnt_q == CntW'(1));
    end

    // Load on start, otherwise step while iterations remain.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dsor_d    = dsor_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        rem_sel_d = rem_sel_q;
        skip_d    = skip_q;
        if (start_i) begin
            rem_sel_d = rem_sel_i;
            dsor_d    = abs2;
            if (div_zero) begin
                quot_d  = '1;
                rem_d   = dividend_i;
                neg_q_d = 1'b0;
                neg_r_d = 1'b0;
                skip_d  = 1'b1;
                cnt_d   = '0;
            end else if (div_ovf) begin
                quot_d  = dividend_i;
                rem_d   = '0;
                neg_q_d = 1'b0;
                neg_r_d = 1'b0;
                skip_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                quot_d  = abs1;
                rem_d   = '0;
                neg_q_d = sign1 ^ sign2;
                neg_r_d = sign1;
                skip_d  = 1'b0;
                cnt_d   = CntStart;
            end
        end else if ((cnt_q != '0) && !stall_i) begin
            rem_d  = st_rem;
            quot_d = st_quot;
            cnt_d  = cnt_q - CntW'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dsor_q    <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dsor_q    <= dsor_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            rem_sel_q <= rem_sel_d;
            skip_q    <= skip_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: routes fast ops through the external alu and divides through
// div_iter, with a one-entry tagged output register.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DIV_ITERS = DIV_ITERS_DEFAULT,
    parameter int unsigned TAG_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_opcode,
    input  logic [63:0]      in_value1,
    input  logic [63:0]      in_value2,
    input  logic [31:0]      in_immediate,
    input  logic [5:0]       in_shamt,
    input  logic [3:0]       in_instr_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic [10:0]      alu_opcode,
    output logic [63:0]      alu_value1,
    output logic [63:0]      alu_value2,
    output logic [31:0]      alu_immediate,
    output logic [5:0]       alu_shamt,
    output logic [3:0]       alu_instr_type,
    input  logic [63:0]      alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    issue_state_e     state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d, tag_q, tag_d;

    logic        out_free, accept, div_op, fast_op, fix_leave, div_stall;
    logic        div_skip, div_done;
    logic [63:0] div_result;

    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = (state_q == StIdle) && out_free;
    assign accept     = in_valid && in_ready;
    assign div_op     = accept && is_div_class(in_opcode);
    assign fast_op    = accept && !is_div_class(in_opcode) && (in_opcode != OP_NOTHING);
    assign fix_leave  = (state_q == StDivFix) && out_free;
    assign div_stall  = (state_q == StDivFix) && !out_free;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = (state_q != StIdle);

    // The alu only sees the operation during the accepting cycle.
    always_comb begin
        alu_opcode     = OP_NOTHING;
        alu_value1     = '0;
        alu_value2     = '0;
        alu_immediate  = '0;
        alu_shamt      = '0;
        alu_instr_type = '0;
        if (accept) begin
            alu_opcode     = in_opcode;
            alu_value1     = in_value1;
            alu_value2     = in_value2;
            alu_immediate  = in_immediate;
            alu_shamt      = in_shamt;
            alu_instr_type = in_instr_type;
        end
    end

    div_iter #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_op),
        .dividend_i (in_value1),
        .divisor_i  (in_value2),
        .signed_i   (is_signed_div(in_opcode)),
        .rem_sel_i  (is_rem(in_opcode)),
        .stall_i    (div_stall),
        .skip_o     (div_skip),
        .done_o     (div_done),
        .result_o   (div_result)
    );

    // Divider sequencing; zero divisor and overflow go straight to the fix-up state.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        unique case (state_q)
            StIdle: begin
                if (div_op) begin
                    tag_d   = in_tag;
                    state_d = div_skip ? StDivFix : StDivRun;
                end
            end
            StDivRun: begin
                if (div_done) state_d = StDivFix;
            end
            StDivFix: begin
                if (out_free) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: drain, then refill from a fast accept or a finished divide.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (fast_op) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_tag_d    = in_tag;
        end else if (fix_leave) begin
            out_valid_d  = 1'b1;
            out_result_d = div_result;
            out_tag_d    = tag_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural alu stand-in.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready;
    logic [10:0] in_opcode;
    logic [63:0] in_value1, in_value2;
    logic [31:0] in_immediate;
    logic [5:0]  in_shamt;
    logic [3:0]  in_instr_type;
    logic [4:0]  in_tag;
    logic [10:0] alu_opcode;
    logic [63:0] alu_value1, alu_value2, alu_result;
    logic [31:0] alu_immediate;
    logic [5:0]  alu_shamt;
    logic [3:0]  alu_instr_type;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [10:0] op;
        logic [3:0]  ty;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [31:0] imm;
        logic [5:0]  sh;
        logic [4:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    alu_issue_ctrl u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_value1      (in_value1),
        .in_value2      (in_value2),
        .in_immediate   (in_immediate),
        .in_shamt       (in_shamt),
        .in_instr_type  (in_instr_type),
        .in_tag         (in_tag),
        .alu_opcode     (alu_opcode),
        .alu_value1     (alu_value1),
        .alu_value2     (alu_value2),
        .alu_immediate  (alu_immediate),
        .alu_shamt      (alu_shamt),
        .alu_instr_type (alu_instr_type),
        .alu_result     (alu_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_tag        (out_tag),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu stand-in for the fast opcodes used here.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            OP_ADD: alu_result = alu_value1 + ((alu_instr_type == ITYPE) ?
                                 {{32{alu_immediate[31]}}, alu_immediate} : alu_value2);
            OP_SUB: alu_result = alu_value1 - alu_value2;
            OP_XOR: alu_result = alu_value1 ^ alu_value2;
            OP_SLL: alu_result = alu_value1 << alu_shamt;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_opcode     = OP_NOTHING;
        in_value1     = '0;
        in_value2     = '0;
        in_immediate  = '0;
        in_shamt      = '0;
        in_instr_type = RTYPE;
        in_tag        = '0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [10:0] op, input logic [63:0] v1, input logic [63:0] v2,
                         input logic [4:0] tag);
        in_valid  = 1'b1;
        in_opcode = op;
        in_value1 = v1;
        in_value2 = v2;
        in_tag    = tag;
        @(negedge clk);
        check("issue_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts cycles after the accept until out_valid; returns on that negedge.
    task automatic wait_result(input int lat, input logic [63:0] exp_r, input logic [4:0] exp_t,
                               input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1 && lat > 1) begin
                check({name, "_busy"}, {63'd0, busy}, 64'd1);
                check({name, "_in_ready_blocked"}, {63'd0, in_ready}, 64'd0);
            end
        end while (!out_valid && k < 200);
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_result"}, out_result, exp_r);
        check({name, "_tag"}, {59'd0, out_tag}, {59'd0, exp_t});
    endtask

    task automatic div_case(input logic [10:0] op, input logic [63:0] v1, input logic [63:0] v2,
                            input logic [4:0] tag, input int lat, input logic [63:0] exp_r,
                            input string name);
        issue(op, v1, v2, tag);
        wait_result(lat, exp_r, tag, name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saw;
        idle_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        vecs[0] = '{OP_ADD, RTYPE, 64'd5,    64'd7,    32'd0,          6'd0, 5'd3, 64'd12};
        vecs[1] = '{OP_SUB, RTYPE, 64'd10,   64'd3,    32'd0,          6'd0, 5'd4, 64'd7};
        vecs[2] = '{OP_XOR, RTYPE, 64'hF0,   64'hFF,   32'd0,          6'd0, 5'd5, 64'h0F};
        vecs[3] = '{OP_ADD, ITYPE, 64'd100,  64'd55,   32'hFFFF_FFFF,  6'd0, 5'd6, 64'd99};
        vecs[4] = '{OP_SLL, RTYPE, 64'd1,    64'd0,    32'd0,          6'd6, 5'd7, 64'd64};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_alu_opcode", {53'd0, alu_opcode}, {53'd0, OP_NOTHING});
        @(posedge clk);
        #1;

        // Back-to-back fast ops: one result per cycle, in order.
        for (int i = 0; i < 5; i++) begin
            in_valid      = 1'b1;
            in_opcode     = vecs[i].op;
            in_instr_type = vecs[i].ty;
            in_value1     = vecs[i].v1;
            in_value2     = vecs[i].v2;
            in_immediate  = vecs[i].imm;
            in_shamt      = vecs[i].sh;
            in_tag        = vecs[i].tag;
            @(negedge clk);
            check("fast_in_ready", {63'd0, in_ready}, 64'd1);
            check("fast_alu_opcode", {53'd0, alu_opcode}, {53'd0, vecs[i].op});
            if (i == 0) begin
                check("fast_first_empty", {63'd0, out_valid}, 64'd0);
            end else begin
                check("fast_out_valid", {63'd0, out_valid}, 64'd1);
                check("fast_result", out_result, vecs[i-1].exp);
                check("fast_tag", {59'd0, out_tag}, {59'd0, vecs[i-1].tag});
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        check("fast_last_valid", {63'd0, out_valid}, 64'd1);
        check("fast_last_result", out_result, 64'd64);
        check("fast_last_tag", {59'd0, out_tag}, 64'd7);
        check("fast_idle_alu_value1", alu_value1, 64'd0);
        @(posedge clk);
        #1;

        // NOTHING is accepted and produces no output.
        issue(OP_NOTHING, 64'd1, 64'd2, 5'd9);
        repeat (3) begin
            @(negedge clk);
            check("nothing_no_output", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Divides: normal path, zero divisor and signed overflow.
        div_case(OP_DIV,  -64'sd20, 64'd3, 5'd7, 65, -64'sd6, "div_neg");
        div_case(OP_REM,  -64'sd20, 64'd3, 5'd8, 65, -64'sd2, "rem_neg");
        div_case(OP_DIV,  64'd20, -64'sd3, 5'd10, 65, -64'sd6, "div_negdivisor");
        div_case(OP_REM,  64'd20, -64'sd3, 5'd11, 65, 64'd2, "rem_negdivisor");
        div_case(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd12, 65,
                 64'h7FFF_FFFF_FFFF_FFFF, "divu_max");
        div_case(OP_REMU, 64'd100, 64'd7, 5'd13, 65, 64'd2, "remu_small");
        div_case(OP_DIV,  64'd42, 64'd0, 5'd14, 2, 64'hFFFF_FFFF_FFFF_FFFF, "div_by_zero");
        div_case(OP_REMU, 64'd42, 64'd0, 5'd15, 2, 64'd42, "remu_by_zero");
        div_case(OP_DIV,  INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 2, INT64_MIN, "div_ovf");
        div_case(OP_REM,  INT64_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 2, 64'd0, "rem_ovf");

        // Backpressure after a completed divide.
        out_ready = 1'b0;
        issue(OP_DIVU, 64'd100, 64'd7, 5'd9);
        wait_result(65, 64'd14, 5'd9, "bp_div");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_result", out_result, 64'd14);
            check("bp_hold_tag", {59'd0, out_tag}, 64'd9);
            check("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        check("bp_not_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        // Release and issue a fast op in the draining cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        in_value1 = 64'd1;
        in_value2 = 64'd2;
        in_tag    = 5'd2;
        @(negedge clk);
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("bp_refill_valid", {63'd0, out_valid}, 64'd1);
        check("bp_refill_result", out_result, 64'd3);
        check("bp_refill_tag", {59'd0, out_tag}, 64'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a divide abandons it.
        issue(OP_DIV, 64'd1000, 64'd3, 5'd1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_busy_after", {63'd0, busy}, 64'd0);
        saw = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("midrst_no_stale", 64'(saw), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
